j_rxer: RTL and testbench
=========================

J_RXER -- requirements
Module: j_rxer

Interface
REQ-001 SHALL have parameter MIDPT, default 7: oversample count (0..15) at which the start bit is validated.
REQ-002 SHALL have port sys_clk  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port resetl  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port bx16  in  1  one-sys_clk-wide strobe at 16x baud; state advances only on strobe cycles except REQ-021/022.
REQ-005 SHALL have port serin  in  1  asynchronous serial line.
REQ-006 SHALL have port rxpol  in  1  1 = line inverted before use.
REQ-007 SHALL have ports paren, even  in  1 each  parity enable; 1 = even parity, 0 = odd.
REQ-008 SHALL have port u2drd  in  1  data-register read strobe, one cycle.
REQ-009 SHALL have port u2clr  in  1  error-clear strobe, one cycle.
REQ-010 SHALL have port dout  out  16  {8'h0, rxd[7:0]} received data.
REQ-011 SHALL have ports rbf, perr, ferr, ovr, rxbrk  out  1 each  buffer full, parity error, framing error, overrun, break detected.
REQ-012 SHALL have port serst  out  1  synchronised, polarity-corrected line level.

Function
REQ-013 SHALL pass serin through two sys_clk flops, then XOR with rxpol, giving rxl (= serst); idle line is rxl=1.
REQ-014 SHALL use states IDLE, START, DATA, PAR, STOP, WAITHI and a 4-bit tick counter tc, bit counter bc[2:0].
REQ-015 IDLE: on bx16 with rxl=0 -> START, tc=0.
REQ-016 START: on bx16 tc increments; at tc==MIDPT, rxl=0 -> DATA with tc=0, bc=0; rxl=1 -> IDLE (false start, no flags).
REQ-017 DATA: on bx16 tc increments mod 16; at tc wrap 15->0 shift rxl into bit 7 of shift register (LSB first); after bc==7 sample -> PAR if paren else STOP; else bc increments.
REQ-018 PAR: sample at wrap; parity error when (XOR of 8 data bits XOR sampled bit) != (even ? 0 : 1); -> STOP.
REQ-019 STOP: sample at wrap; on the same cycle load rxd from shift register, set rbf, set perr if REQ-018 error, set ferr if stop bit 0, set rxbrk if stop bit 0 and all data (and parity, if enabled) bits 0; -> IDLE if stop bit 1 else WAITHI.
REQ-020 WAITHI: stay until bx16 with rxl=1 -> IDLE; no new start accepted meanwhile.
REQ-021 u2drd (any cycle) SHALL clear rbf next cycle; rxd unchanged.
REQ-022 u2clr (any cycle) SHALL clear perr, ferr, ovr, rxbrk next cycle.
REQ-023 Load with rbf=1 and no simultaneous u2drd SHALL overwrite rxd and set ovr; load with simultaneous u2drd SHALL leave rbf=1, ovr unchanged.
REQ-024 Error set in the same cycle as u2clr SHALL win (flag = 1).
REQ-025 Error flags SHALL be sticky: a later clean frame does not clear them.
REQ-026 Latency: rbf rises one sys_clk after the bx16 strobe sampling mid-stop (~9.5 / 10.5 bit times after the start edge).
REQ-027 bx16 stalled SHALL freeze the receive state machine; strobes continue to act.
REQ-028 paren/even changes mid-frame take effect at the next state decision; no glitch protection required.

Reset
REQ-029 resetl=0 on a sys_clk edge SHALL force IDLE, tc=0, bc=0, shift register=0, rxd=0, rbf=perr=ferr=ovr=rxbrk=0, synchroniser flops=1; reset mid-frame discards the frame.
REQ-030 serst SHALL read rxpol^1 during reset and two cycles after.

Verification
REQ-031 8N1 frame 0xA5, rxpol=0, paren=0 -> rbf=1, dout=16'h00A5, perr=ferr=ovr=0; u2drd -> rbf=0, dout still 16'h00A5.
REQ-032 8E1 frame 0x03 with parity bit 1 (wrong), even=1 -> dout=16'h0003, perr=1; u2clr -> perr=0.
REQ-033 Two frames 0x11 then 0x22 without u2drd -> dout=16'h0022, rbf=1, ovr=1; repeat with u2drd on the load cycle -> ovr=0, rbf=1.
REQ-034 Line held low 20 bit times -> one load: dout=0, ferr=1, rxbrk=1, state WAITHI; no second load until line high, then 0x5A frame received correctly.
REQ-035 Low glitch of 4 bx16 ticks on idle line -> returns to IDLE, rbf stays 0, no flags; rxpol=1 with inverted 0xC3 frame -> dout=16'h00C3.
REQ-036 resetl=0 asserted during bit 4 of a frame -> all outputs 0 next cycle; following full frame 0x7E received cleanly.

Source files
------------

// File: rtl/j_rxer_if.sv
// j_rxer_if: host/line side signal bundle of the j_rxer serial receiver.
interface j_rxer_if;
   logic        bx16;
   logic        serin;
   logic        rxpol;
   logic        paren;
   logic        even;
   logic        u2drd;
   logic        u2clr;
   logic [15:0] dout;
   logic        rbf;
   logic        perr;
   logic        ferr;
   logic        ovr;
   logic        rxbrk;
   logic        serst;

   modport master (
      output bx16, serin, rxpol, paren, even, u2drd, u2clr,
      input  dout, rbf, perr, ferr, ovr, rxbrk, serst
   );

   modport slave (
      input  bx16, serin, rxpol, paren, even, u2drd, u2clr,
      output dout, rbf, perr, ferr, ovr, rxbrk, serst
   );
endinterface

// File: rtl/j_rxer.sv
// j_rxer: 16x-oversampled async serial receiver with parity, framing, overrun and break status.
module j_rxer #(
   parameter int unsigned MIDPT = 7
) (
   input  logic    sys_clk,
   input  logic    resetl,
   j_rxer_if.slave bus
);
   localparam int unsigned TCW = 4;
   localparam int unsigned BCW = 3;
   localparam int unsigned DW  = 8;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PAR    = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_WAITHI = 3'd5;

   localparam logic [TCW-1:0] TC_MID  = TCW'(MIDPT);
   localparam logic [TCW-1:0] TC_LAST = '1;
   localparam logic [BCW-1:0] BC_LAST = '1;

   logic [1:0]     r_sync;
   logic [2:0]     r_state;
   logic [TCW-1:0] r_tc;
   logic [BCW-1:0] r_bc;
   logic [DW-1:0]  r_shf;
   logic           r_pbit;
   logic           r_perr_pend;
   logic [DW-1:0]  r_rxd;
   logic           r_rbf;
   logic           r_perr;
   logic           r_ferr;
   logic           r_ovr;
   logic           r_rxbrk;

   logic [2:0]     w_state_nx;
   logic [TCW-1:0] w_tc_nx;
   logic [BCW-1:0] w_bc_nx;
   logic [DW-1:0]  w_shf_nx;
   logic           w_pbit_nx;
   logic           w_perr_pend_nx;
   logic           w_load;
   logic           w_stop_bad;
   logic           w_rxl;
   logic           w_wrap;
   logic           w_brk;

   assign w_rxl  = r_sync[1] ^ bus.rxpol;
   assign w_wrap = (r_tc == TC_LAST);
   // Break: stop low and every sampled data/parity bit low (r_pbit is 0 when no parity).
   assign w_brk  = w_stop_bad && (r_shf == '0) && !r_pbit;

   // Two-flop synchroniser on the raw line; idles high out of reset.
   always_ff @(posedge sys_clk) begin
      if (!resetl) r_sync <= 2'b11;
      else         r_sync <= {r_sync[0], bus.serin};
   end

   // Receive state register.
   always_ff @(posedge sys_clk) begin
      if (!resetl) begin
         r_state     <= S_IDLE;
         r_tc        <= '0;
         r_bc        <= '0;
         r_shf       <= '0;
         r_pbit      <= 1'b0;
         r_perr_pend <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_tc        <= w_tc_nx;
         r_bc        <= w_bc_nx;
         r_shf       <= w_shf_nx;
         r_pbit      <= w_pbit_nx;
         r_perr_pend <= w_perr_pend_nx;
      end
   end

   // Next-state logic; only bx16 cycles move the receiver.
   always_comb begin
      w_state_nx     = r_state;
      w_tc_nx        = r_tc;
      w_bc_nx        = r_bc;
      w_shf_nx       = r_shf;
      w_pbit_nx      = r_pbit;
      w_perr_pend_nx = r_perr_pend;
      w_load         = 1'b0;
      w_stop_bad     = 1'b0;
      if (bus.bx16) begin
         case (r_state)
            S_IDLE: begin
               if (!w_rxl) begin
                  w_state_nx = S_START;
                  w_tc_nx    = '0;
               end
            end
            S_START: begin
               if (r_tc == TC_MID) begin
                  w_tc_nx    = '0;
                  w_bc_nx    = '0;
                  w_state_nx = w_rxl ? S_IDLE : S_DATA;
               end else begin
                  w_tc_nx = r_tc + TCW'(1);
               end
            end
            S_DATA: begin
               w_tc_nx = r_tc + TCW'(1);
               if (w_wrap) begin
                  w_shf_nx = {w_rxl, r_shf[DW-1:1]};
                  if (r_bc == BC_LAST) begin
                     w_pbit_nx      = 1'b0;
                     w_perr_pend_nx = 1'b0;
                     w_state_nx     = bus.paren ? S_PAR : S_STOP;
                  end else begin
                     w_bc_nx = r_bc + BCW'(1);
                  end
               end
            end
            S_PAR: begin
               w_tc_nx = r_tc + TCW'(1);
               if (w_wrap) begin
                  w_pbit_nx      = w_rxl;
                  w_perr_pend_nx = (^r_shf) ^ w_rxl ^ !bus.even;
                  w_state_nx     = S_STOP;
               end
            end
            S_STOP: begin
               w_tc_nx = r_tc + TCW'(1);
               if (w_wrap) begin
                  w_load     = 1'b1;
                  w_stop_bad = !w_rxl;
                  w_state_nx = w_rxl ? S_IDLE : S_WAITHI;
               end
            end
            S_WAITHI: begin
               if (w_rxl) w_state_nx = S_IDLE;
            end
            default: begin
               w_state_nx = S_IDLE;
               w_tc_nx    = '0;
            end
         endcase
      end
   end

   // Data register and sticky status; a new error beats a same-cycle clear.
   always_ff @(posedge sys_clk) begin
      if (!resetl) begin
         r_rxd   <= '0;
         r_rbf   <= 1'b0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
         r_rxbrk <= 1'b0;
      end else begin
         if (w_load) begin
            r_rxd <= r_shf;
            r_rbf <= 1'b1;
         end else if (bus.u2drd) begin
            r_rbf <= 1'b0;
         end

         if (w_load && r_rbf && !bus.u2drd) r_ovr <= 1'b1;
         else if (bus.u2clr)                r_ovr <= 1'b0;

         if (w_load && r_perr_pend) r_perr <= 1'b1;
         else if (bus.u2clr)        r_perr <= 1'b0;

         if (w_load && w_stop_bad) r_ferr <= 1'b1;
         else if (bus.u2clr)       r_ferr <= 1'b0;

         if (w_load && w_brk) r_rxbrk <= 1'b1;
         else if (bus.u2clr)  r_rxbrk <= 1'b0;
      end
   end

   assign bus.dout  = {8'h00, r_rxd};
   assign bus.rbf   = r_rbf;
   assign bus.perr  = r_perr;
   assign bus.ferr  = r_ferr;
   assign bus.ovr   = r_ovr;
   assign bus.rxbrk = r_rxbrk;
   assign bus.serst = w_rxl;
endmodule

// File: tb/tb_j_rxer.sv
// tb_j_rxer: vector table, corner sequences and random frames against a frame-level model.
`timescale 1ns/1ps
module tb_j_rxer;
   localparam int unsigned DIV = 2;
   localparam int unsigned BIT = 16 * DIV;
   localparam int unsigned LIM = 2000;

   typedef struct {
      logic [7:0]  d;
      bit          pe;
      bit          ev;
      bit          pb;
      bit          st;
      bit          rd;
      bit          clr;
      logic [15:0] x_dout;
      bit          x_rbf;
      bit          x_perr;
      bit          x_ferr;
      bit          x_ovr;
      bit          x_brk;
   } vec_t;

   logic        sys_clk = 1'b0;
   logic        resetl;
   int unsigned sc = 0;
   int          checks = 0;
   int          errors = 0;
   int unsigned k;
   vec_t        vt [10];

   logic [7:0]  d;
   bit          pe, ev, pb, st;
   logic [7:0]  m_rxd;
   bit          m_rbf, m_perr, m_ferr, m_ovr, m_brk;

   j_rxer_if bus ();

   j_rxer #(.MIDPT(7)) dut (
      .sys_clk (sys_clk),
      .resetl  (resetl),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   // 16x strobe, one cycle in DIV.
   initial begin
      bus.bx16 = 1'b0;
      forever begin
         @(posedge sys_clk);
         #1;
         sc = (sc + 1) % DIV;
         bus.bx16 = (sc == 0);
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int unsigned n);
      repeat (n) @(posedge sys_clk);
      #2;
   endtask

   task automatic align();
      do cyc(1); while (sc != 0);
   endtask

   task automatic drive(input bit lvl, input int unsigned n);
      bus.serin = lvl ^ bus.rxpol;
      cyc(n);
   endtask

   task automatic frame_body(input logic [7:0] fd, input bit fpe, input bit fpb, input bit fst);
      drive(1'b0, BIT);
      for (int i = 0; i < 8; i++) drive(fd[i], BIT);
      if (fpe) drive(fpb, BIT);
      drive(fst, BIT);
      drive(1'b1, 2 * BIT);
   endtask

   task automatic send_frame(input logic [7:0] fd, input bit fpe, input bit fpb, input bit fst);
      align();
      frame_body(fd, fpe, fpb, fst);
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [15:0] xd, input bit xr,
                          input bit xp, input bit xf, input bit xo, input bit xb);
      chk({tag, ".dout"},  bus.dout,         xd);
      chk({tag, ".rbf"},   16'(bus.rbf),     16'(xr));
      chk({tag, ".perr"},  16'(bus.perr),    16'(xp));
      chk({tag, ".ferr"},  16'(bus.ferr),    16'(xf));
      chk({tag, ".ovr"},   16'(bus.ovr),     16'(xo));
      chk({tag, ".rxbrk"}, 16'(bus.rxbrk),   16'(xb));
   endtask

   task automatic pulse_rd();
      bus.u2drd = 1'b1;
      cyc(1);
      bus.u2drd = 1'b0;
      cyc(1);
   endtask

   task automatic pulse_clr();
      bus.u2clr = 1'b1;
      cyc(1);
      bus.u2clr = 1'b0;
      cyc(1);
   endtask

   function automatic bit par_ok(input logic [7:0] pd, input bit pev);
      return (($countones(pd) % 2) != (pev ? 0 : 1));
   endfunction

   initial begin
      //          d      pe ev pb st rd clr  dout      rbf perr ferr ovr brk
      vt[0] = '{8'hA5, 0, 0, 0, 1, 1, 0, 16'h00A5, 1, 0, 0, 0, 0};
      vt[1] = '{8'h03, 1, 1, 1, 1, 1, 1, 16'h0003, 1, 1, 0, 0, 0};
      vt[2] = '{8'h03, 1, 1, 0, 1, 0, 0, 16'h0003, 1, 0, 0, 0, 0};
      vt[3] = '{8'h11, 0, 0, 0, 1, 0, 0, 16'h0011, 1, 0, 0, 1, 0};
      vt[4] = '{8'h22, 0, 0, 0, 1, 1, 1, 16'h0022, 1, 0, 0, 1, 0};
      vt[5] = '{8'h5A, 1, 0, 1, 1, 1, 0, 16'h005A, 1, 0, 0, 0, 0};
      vt[6] = '{8'h00, 0, 0, 0, 0, 1, 0, 16'h0000, 1, 0, 1, 0, 1};
      vt[7] = '{8'hFF, 0, 0, 0, 1, 1, 1, 16'h00FF, 1, 0, 1, 0, 1};
      vt[8] = '{8'h00, 1, 1, 1, 0, 1, 1, 16'h0000, 1, 1, 1, 0, 0};
      vt[9] = '{8'h80, 1, 0, 0, 0, 1, 1, 16'h0080, 1, 0, 1, 0, 0};

      resetl    = 1'b0;
      bus.rxpol = 1'b0;
      bus.paren = 1'b0;
      bus.even  = 1'b0;
      bus.u2drd = 1'b0;
      bus.u2clr = 1'b0;
      bus.serin = 1'b1;
      cyc(4);
      chk("rst.serst", 16'(bus.serst), 16'd1);
      resetl = 1'b1;
      cyc(1);
      chk_out("rst", 16'h0000, 0, 0, 0, 0, 0);
      drive(1'b1, 2 * BIT);

      // Vector table.
      for (int i = 0; i < 10; i++) begin
         bus.paren = vt[i].pe;
         bus.even  = vt[i].ev;
         send_frame(vt[i].d, vt[i].pe, vt[i].pb, vt[i].st);
         chk_out($sformatf("vec%0d", i), vt[i].x_dout, vt[i].x_rbf, vt[i].x_perr,
                 vt[i].x_ferr, vt[i].x_ovr, vt[i].x_brk);
         if (vt[i].rd) begin
            pulse_rd();
            chk($sformatf("vec%0d.rd.rbf", i),  16'(bus.rbf), 16'd0);
            chk($sformatf("vec%0d.rd.dout", i), bus.dout,     vt[i].x_dout);
         end
         if (vt[i].clr) begin
            pulse_clr();
            chk($sformatf("vec%0d.clr.flags", i),
                16'({bus.perr, bus.ferr, bus.ovr, bus.rxbrk}), 16'd0);
         end
      end

      // Read strobe on the exact load cycle: rbf stays set, no overrun.
      bus.paren = 1'b0;
      align();
      fork
         frame_body(8'h11, 0, 0, 1);
         begin
            k = 0;
            while (bus.rbf !== 1'b1 && k < LIM) begin
               cyc(1);
               k++;
            end
         end
      join
      chk("lat.bound", 16'(k < LIM), 16'd1);
      chk("lat.range", 16'(k >= 150 * DIV && k <= 158 * DIV), 16'd1);
      align();
      fork
         frame_body(8'h22, 0, 0, 1);
         begin
            cyc(k - 1);
            bus.u2drd = 1'b1;
            cyc(1);
            bus.u2drd = 1'b0;
         end
      join
      chk_out("rdload", 16'h0022, 1, 0, 0, 0, 0);
      pulse_rd();

      // Long break: one load, none while the line stays low.
      align();
      drive(1'b0, 12 * BIT);
      chk_out("brk1", 16'h0000, 1, 0, 1, 0, 1);
      pulse_rd();
      drive(1'b0, 8 * BIT);
      chk_out("brk2", 16'h0000, 0, 0, 1, 0, 1);
      drive(1'b1, 2 * BIT);
      pulse_clr();
      send_frame(8'h5A, 0, 0, 1);
      chk_out("brk3", 16'h005A, 1, 0, 0, 0, 0);
      pulse_rd();

      // Short low glitch is a false start.
      align();
      drive(1'b0, 4 * DIV);
      drive(1'b1, 2 * BIT);
      chk_out("glitch", 16'h005A, 0, 0, 0, 0, 0);

      // Inverted line.
      bus.rxpol = 1'b1;
      drive(1'b1, 2 * BIT);
      chk("inv.serst", 16'(bus.serst), 16'd1);
      send_frame(8'hC3, 0, 0, 1);
      chk_out("inv", 16'h00C3, 1, 0, 0, 0, 0);

      // Reset during data bit 4 of 0xA6, with rbf still set.
      d = 8'hA6;
      align();
      drive(1'b0, BIT);
      for (int i = 0; i < 4; i++) drive(d[i], BIT);
      drive(d[4], BIT / 2);
      resetl = 1'b0;
      cyc(1);
      chk_out("midrst", 16'h0000, 0, 0, 0, 0, 0);
      chk("midrst.serst", 16'(bus.serst), 16'd0);
      resetl = 1'b1;
      cyc(1);
      chk("postrst.serst", 16'(bus.serst), 16'd0);
      drive(1'b1, 3 * BIT);
      chk_out("abort", 16'h0000, 0, 0, 0, 0, 0);
      send_frame(8'h7E, 0, 0, 1);
      chk_out("post", 16'h007E, 1, 0, 0, 0, 0);

      // Random frames against a frame-level model.
      m_rxd = 8'h7E;
      m_rbf = 1'b1;
      m_perr = 1'b0;
      m_ferr = 1'b0;
      m_ovr = 1'b0;
      m_brk = 1'b0;
      for (int n = 0; n < 16; n++) begin
         d  = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 4) == 0) d = 8'h00;
         pe = 1'($urandom_range(0, 1));
         ev = 1'($urandom_range(0, 1));
         st = ($urandom_range(0, 3) != 0);
         pb = par_ok(d, ev) ^ ($urandom_range(0, 3) == 0);
         bus.paren = pe;
         bus.even  = ev;
         send_frame(d, pe, pb, st);
         if (m_rbf) m_ovr = 1'b1;
         m_rbf = 1'b1;
         m_rxd = d;
         if (pe && ((($countones(d) + int'(pb)) % 2) != (ev ? 0 : 1))) m_perr = 1'b1;
         if (!st) begin
            m_ferr = 1'b1;
            if (d == 8'h00 && (!pe || !pb)) m_brk = 1'b1;
         end
         chk_out($sformatf("rnd%0d", n), {8'h00, m_rxd}, m_rbf, m_perr, m_ferr, m_ovr, m_brk);
         if ($urandom_range(0, 1) == 1) begin
            pulse_rd();
            m_rbf = 1'b0;
         end
         if ($urandom_range(0, 2) == 0) begin
            pulse_clr();
            m_perr = 1'b0;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            m_brk  = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
